// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder memory-side handshake block.
// The LFSR seed, taps and step function are used only when MEM_RAND_LAT_EN is defined.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word array behind mem_responder: combinational read, byte-masked write on posedge.
// Contents are never reset.
module mem_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clock,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic                  we_i,
  input  logic [3:0]            wmask_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];

  assign rdata_o = mem_q[idx_i];

  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_i[i]) mem_q[idx_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// IFU/LSU memory responder: one request at a time, fixed (or LFSR-jittered) latency.
// Optional feature macro: MEM_RAND_LAT_EN adds LFSR-driven latency of LATENCY..LATENCY+3.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        busy
);

  localparam int CNT_W = $clog2(LATENCY + 4) + 1;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  wen_q, wen_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [31:0]           ifu_rdata_q, ifu_rdata_d;
  logic [31:0]           lsu_rdata_q, lsu_rdata_d;

  logic                  enter_resp;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_wen;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_wmask;
  owner_e                acc_owner;
  logic [31:0]           arr_rdata;
  logic [CNT_W-1:0]      lat;

  // Only the word index takes part; higher bits alias (wrap) and byte offset is ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ifu_addr[31:DEPTH_LOG2+2], ifu_addr[1:0],
                              lsu_addr[31:DEPTH_LOG2+2], lsu_addr[1:0]};

`ifdef MEM_RAND_LAT_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_step(lfsr_q);
  end

  assign lat = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  assign lat = CNT_W'(LATENCY);
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    enter_resp = 1'b0;
    acc_idx    = idx_q;
    acc_wen    = wen_q;
    acc_wdata  = wdata_q;
    acc_wmask  = wmask_q;
    acc_owner  = owner_q;
    case (state_q)
      IDLE, RESP: begin
        if (lsu_reqValid || ifu_reqValid) begin
          owner_d = lsu_reqValid ? OWN_LSU : OWN_IFU;
          idx_d   = lsu_reqValid ? lsu_addr[DEPTH_LOG2+1:2] : ifu_addr[DEPTH_LOG2+1:2];
          wen_d   = lsu_reqValid && lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          if (lat == CNT_W'(1)) begin
            // Single-cycle latency: the access uses the request being accepted right now
            state_d    = RESP;
            enter_resp = 1'b1;
            acc_idx    = idx_d;
            acc_wen    = wen_d;
            acc_wdata  = wdata_d;
            acc_wmask  = wmask_d;
            acc_owner  = owner_d;
          end else begin
            state_d = WAIT;
            cnt_d   = lat - CNT_W'(2);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    if (enter_resp) begin
      if (acc_owner == OWN_LSU) lsu_rdata_d = arr_rdata;
      else                      ifu_rdata_d = arr_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IFU;
      cnt_q       <= '0;
      idx_q       <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  // Reset must win over a store landing on the same edge
  mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clock  (clock),
    .idx_i  (acc_idx),
    .we_i   (enter_resp && acc_wen && !reset),
    .wmask_i(acc_wmask),
    .wdata_i(acc_wdata),
    .rdata_o(arr_rdata)
  );

  assign ifu_respValid = (state_q == RESP) && (owner_q == OWN_IFU);
  assign lsu_respValid = (state_q == RESP) && (owner_q == OWN_LSU);
  assign busy          = (state_q != IDLE);
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule
